circle_extent_detector: RTL
===========================

Name: circle_extent_detector

Overview:
- Inverse of the circle renderer: consumes the per-pixel object mask stream (hcount/vcount raster plus a 1-bit mask) and recovers the parameters the renderer needs.
- Per frame it produces two points (xmin, ycentroid) and (xmax, ycentroid), plus centroid x and radius.
- Sits between the colour-threshold mask stage and the circle draw stage, so a detected blob can be redrawn as a clean circle.

Parameters:
- MIN_PIXELS, 16: minimum masked-pixel count for a frame to report found_out=1.
- COUNT_WIDTH, 21: width of the pixel counter and divisor. Must hold 1280*720 pixels.
- SUM_WIDTH, 32: width of the sum_x and sum_y accumulators and the dividend.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous reset, active-low.
- hcount_in  input  11  current pixel x.
- vcount_in  input  10  current pixel y.
- valid_in  input  1  pixel qualifier.
- mask_in  input  1  pixel belongs to object.
- new_frame_in  input  1  single-cycle pulse at frame boundary.
- x_out_1  output  11  min masked x.
- y_out_1  output  10  centroid y.
- x_out_2  output  11  max masked x.
- y_out_2  output  10  centroid y (same value as y_out_1).
- x_center_out  output  11  centroid x.
- radius_out  output  11  (xmax-xmin)>>1.
- found_out  output  1  last result had count >= MIN_PIXELS.
- valid_out  output  1  one-cycle result strobe.
- overrun_out  output  1  one-cycle strobe: a frame was dropped.

Behaviour:
- Reset (rst_in==0 at a clock edge):
  - All outputs go to 0, state IDLE, accumulators cleared.
  - Reset mid-DIVIDE aborts the division with no valid_out.
- A pixel is counted when valid_in && mask_in. Counting updates:
  - count += 1; sum_x += hcount_in; sum_y += vcount_in;
  - xmin = min(xmin, hcount_in); xmax = max(xmax, hcount_in).
- Accumulator clear values: count=0, sums=0, xmin=2047, xmax=0.
- States:
  - IDLE: pixels ignored. On new_frame_in: clear accumulators, go to ACCUM.
  - ACCUM: accumulate pixels. On new_frame_in (edge N):
    - Snapshot count, sums, xmin and xmax into working registers, then clear the accumulators.
    - If snapshot count < MIN_PIXELS: found_out=0 and valid_out=1 after edge N+1. Coordinate outputs keep their previous values. Stay in ACCUM.
    - Otherwise go to DIVIDE.
  - DIVIDE:
    - Two parallel restoring dividers, sum_x/count and sum_y/count, one quotient bit per cycle, SUM_WIDTH iterations (edges N+1..N+32).
    - Accumulation of the next frame continues throughout.
    - At edge N+33: register the outputs (x_center_out, y_out_1, y_out_2, x_out_1=xmin, x_out_2=xmax, radius_out), set found_out=1, assert valid_out, return to ACCUM.
- new_frame_in during DIVIDE:
  - Accumulators are cleared and that frame's snapshot is discarded.
  - overrun_out pulses one cycle after that edge.
  - The in-flight division completes normally.
- Pixel on the same cycle as new_frame_in: counted into the fresh (next-frame) accumulators, never the snapshot.
- Division is floor (truncating). Quotient is truncated to the output width; the true result always fits.
- radius_out = (xmax - xmin) >> 1, unsigned; xmax >= xmin is guaranteed when found.
- Counter saturation: count saturates at 2^COUNT_WIDTH-1. Sums wrap; this is unreachable at 1280x720.
- valid_out and overrun_out are high for exactly one cycle per event. All other outputs hold between results.
- Latency: new_frame_in to valid_out is 34 cycles (found) or 2 cycles (not found).

Test Plan:
- Rectangle of masked pixels x 100..139, y 50..59 (count 400), then new_frame_in -> 34 cycles later valid_out=1, found_out=1, x_out_1=100, x_out_2=139, x_center_out=119, y_out_1=y_out_2=54, radius_out=19.
- Frame with 5 masked pixels (MIN_PIXELS=16) -> valid_out 2 cycles after new_frame_in, found_out=0, coordinate outputs unchanged from the prior result.
- Second new_frame_in 10 cycles after the first found frame -> overrun_out pulses once; the first result is still reported correctly at cycle 34; the next valid frame is accumulated from zero.
- Masked pixel (x=7,y=3) presented together with new_frame_in, then 20 pixels at (200,100), then new_frame_in -> count 21, x_out_1=7, x_out_2=200, x_center_out=(7+4000)/21=190, y centroid=(3+2000)/21=95.
- rst_in low for 1 cycle at DIVIDE cycle 15 -> no valid_out, all outputs 0, state IDLE; the next new_frame_in only starts accumulation and produces no result.
- Pixels with valid_in=0, mask_in=1 and pixels before the first new_frame_in after reset -> never counted; an all-zero frame reports found_out=0.

Source files
------------

// File: rtl/circle_extent_detector.sv
// rtl/circle_extent_detector.sv - recovers min/max x, centroid and radius of a masked blob per frame
module circle_extent_detector #(
    parameter int MIN_PIXELS  = 16,
    parameter int COUNT_WIDTH = 21,
    parameter int SUM_WIDTH   = 32
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        valid_in,
    input  logic        mask_in,
    input  logic        new_frame_in,
    output logic [10:0] x_out_1,
    output logic [9:0]  y_out_1,
    output logic [10:0] x_out_2,
    output logic [9:0]  y_out_2,
    output logic [10:0] x_center_out,
    output logic [10:0] radius_out,
    output logic        found_out,
    output logic        valid_out,
    output logic        overrun_out
);
    localparam int REM_W  = COUNT_WIDTH + 1;
    localparam int ITER_W = $clog2(SUM_WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DIVIDE} state_t;

    state_t                 r_state;
    logic [COUNT_WIDTH-1:0] r_count;
    logic [SUM_WIDTH-1:0]   r_sum_x, r_sum_y;
    logic [10:0]            r_xmin, r_xmax;
    logic [COUNT_WIDTH-1:0] r_div;
    logic [SUM_WIDTH-1:0]   r_qx, r_qy;
    logic [COUNT_WIDTH-1:0] r_remx, r_remy;
    logic [10:0]            r_wxmin, r_wxmax;
    logic [ITER_W-1:0]      r_iter;
    logic                   r_miss;

    // A pixel arriving with new_frame_in lands in the freshly cleared accumulators.
    logic                   w_pixel;
    logic [COUNT_WIDTH-1:0] w_base_count, w_count_next;
    logic [SUM_WIDTH-1:0]   w_base_sum_x, w_base_sum_y, w_sum_x_next, w_sum_y_next;
    logic [10:0]            w_base_xmin, w_base_xmax, w_xmin_next, w_xmax_next;

    assign w_pixel      = valid_in && mask_in && ((r_state != S_IDLE) || new_frame_in);
    assign w_base_count = new_frame_in ? '0 : r_count;
    assign w_base_sum_x = new_frame_in ? '0 : r_sum_x;
    assign w_base_sum_y = new_frame_in ? '0 : r_sum_y;
    assign w_base_xmin  = new_frame_in ? 11'd2047 : r_xmin;
    assign w_base_xmax  = new_frame_in ? 11'd0 : r_xmax;

    assign w_count_next = (w_pixel && (w_base_count != {COUNT_WIDTH{1'b1}}))
                        ? w_base_count + 1'b1 : w_base_count;
    assign w_sum_x_next = w_base_sum_x + (w_pixel ? SUM_WIDTH'(hcount_in) : '0);
    assign w_sum_y_next = w_base_sum_y + (w_pixel ? SUM_WIDTH'(vcount_in) : '0);
    assign w_xmin_next  = (w_pixel && (hcount_in < w_base_xmin)) ? hcount_in : w_base_xmin;
    assign w_xmax_next  = (w_pixel && (hcount_in > w_base_xmax)) ? hcount_in : w_base_xmax;

    // Restoring division step: shift the next dividend bit into the partial remainder.
    logic [REM_W-1:0] w_remx_sh, w_remy_sh, w_divisor;
    logic             w_remx_ge, w_remy_ge;

    assign w_divisor = {1'b0, r_div};
    assign w_remx_sh = {r_remx, r_qx[SUM_WIDTH-1]};
    assign w_remy_sh = {r_remy, r_qy[SUM_WIDTH-1]};
    assign w_remx_ge = (w_remx_sh >= w_divisor);
    assign w_remy_ge = (w_remy_sh >= w_divisor);

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_state      <= S_IDLE;
            r_count      <= '0;
            r_sum_x      <= '0;
            r_sum_y      <= '0;
            r_xmin       <= 11'd2047;
            r_xmax       <= '0;
            r_div        <= '0;
            r_qx         <= '0;
            r_qy         <= '0;
            r_remx       <= '0;
            r_remy       <= '0;
            r_wxmin      <= '0;
            r_wxmax      <= '0;
            r_iter       <= '0;
            r_miss       <= 1'b0;
            x_out_1      <= '0;
            y_out_1      <= '0;
            x_out_2      <= '0;
            y_out_2      <= '0;
            x_center_out <= '0;
            radius_out   <= '0;
            found_out    <= 1'b0;
            valid_out    <= 1'b0;
            overrun_out  <= 1'b0;
        end else begin
            valid_out   <= 1'b0;
            overrun_out <= 1'b0;
            r_count     <= w_count_next;
            r_sum_x     <= w_sum_x_next;
            r_sum_y     <= w_sum_y_next;
            r_xmin      <= w_xmin_next;
            r_xmax      <= w_xmax_next;

            if (r_miss) begin
                r_miss    <= 1'b0;
                valid_out <= 1'b1;
                found_out <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (new_frame_in)
                        r_state <= S_ACCUM;
                end
                S_ACCUM: begin
                    if (new_frame_in) begin
                        if (r_count < COUNT_WIDTH'(MIN_PIXELS)) begin
                            r_miss <= 1'b1;
                        end else begin
                            r_div   <= r_count;
                            r_qx    <= r_sum_x;
                            r_qy    <= r_sum_y;
                            r_remx  <= '0;
                            r_remy  <= '0;
                            r_wxmin <= r_xmin;
                            r_wxmax <= r_xmax;
                            r_iter  <= '0;
                            r_state <= S_DIVIDE;
                        end
                    end
                end
                S_DIVIDE: begin
                    if (new_frame_in)
                        overrun_out <= 1'b1;
                    if (r_iter == ITER_W'(SUM_WIDTH)) begin
                        x_center_out <= r_qx[10:0];
                        y_out_1      <= r_qy[9:0];
                        y_out_2      <= r_qy[9:0];
                        x_out_1      <= r_wxmin;
                        x_out_2      <= r_wxmax;
                        radius_out   <= (r_wxmax - r_wxmin) >> 1;
                        found_out    <= 1'b1;
                        valid_out    <= 1'b1;
                        r_state      <= S_ACCUM;
                    end else begin
                        r_remx <= w_remx_ge ? COUNT_WIDTH'(w_remx_sh - w_divisor)
                                            : COUNT_WIDTH'(w_remx_sh);
                        r_remy <= w_remy_ge ? COUNT_WIDTH'(w_remy_sh - w_divisor)
                                            : COUNT_WIDTH'(w_remy_sh);
                        r_qx   <= {r_qx[SUM_WIDTH-2:0], w_remx_ge};
                        r_qy   <= {r_qy[SUM_WIDTH-2:0], w_remy_ge};
                        r_iter <= r_iter + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
